fb_write_arbiter: RTL and testbench

Shares the single framebuffer write port (fb_we / fb_addr / fb_wdata) between three screen renderers (start, play, win/overlay) and adds a built-in clear engine that fills the whole framebuffer with one colour. It sits between the renderers and the framebuffer RAM inside the game top level. Requesters use a valid/ready handshake, arbitration is round-robin with an optional bus lock, and all framebuffer outputs are registered.

---
 rtl/fb_write_arbiter.sv | 174 +++++++++++++++++
 tb/tb_fb_write_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port arbiter: round-robin sharing between three renderers with
// an optional bus lock, plus a built-in engine that fills the framebuffer with one colour.
module fb_write_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int FB_WORDS = 19200,
    parameter int LOCK_MAX = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [2:0]          req_valid,
    input  logic [2:0]          req_lock,
    input  logic [3*ADDR_W-1:0] req_addr,
    input  logic [3*DATA_W-1:0] req_data,
    output logic [2:0]          req_ready,
    input  logic                clear_start,
    input  logic [DATA_W-1:0]   clear_color,
    output logic                clear_busy,
    output logic                clear_done,
    output logic [1:0]          grant_id,
    output logic                fb_we,
    output logic [ADDR_W-1:0]   fb_addr,
    output logic [DATA_W-1:0]   fb_wdata
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [ADDR_W:0]  LAST_IDX = (ADDR_W + 1)'(FB_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    typedef enum logic {
        ST_ARB,
        ST_CLEAR
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          rr_ptr;
    logic [1:0]          lock_owner;
    logic                locked;
    logic [CNT_W-1:0]    lock_cnt;
    logic [ADDR_W:0]     clear_idx;
    logic [DATA_W-1:0]   clear_color_q;

    logic [1:0]          win_id;
    logic                win_found;
    logic [2:0]          scan_sum;
    logic [1:0]          scan_cand;
    logic [1:0]          xfer_id;
    logic                xfer;
    logic                start_clear;
    logic                clear_last;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    function automatic logic [1:0] ptr_after(input logic [1:0] id);
        return (id == 2'd2) ? 2'd0 : id + 2'd1;
    endfunction

    // Scan highest-to-lowest priority so the candidate nearest the pointer is kept last.
    always_comb begin
        win_found = 1'b0;
        win_id    = 2'd0;
        scan_sum  = 3'd0;
        scan_cand = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            scan_sum  = {1'b0, rr_ptr} + 3'(k);
            scan_cand = (scan_sum >= 3'd3) ? 2'(scan_sum - 3'd3) : scan_sum[1:0];
            if (req_valid[scan_cand]) begin
                win_found = 1'b1;
                win_id    = scan_cand;
            end
        end
    end

    always_comb begin
        start_clear = (state_q == ST_ARB) && clear_start;
        clear_last  = (state_q == ST_CLEAR) && (clear_idx == LAST_IDX);
        req_ready   = 3'b000;
        if ((state_q == ST_ARB) && !clear_start) begin
            if (locked) begin
                req_ready[lock_owner] = req_valid[lock_owner];
            end else if (win_found) begin
                req_ready[win_id] = 1'b1;
            end
        end
        xfer    = |(req_valid & req_ready);
        xfer_id = locked ? lock_owner : win_id;
    end

    always_comb begin
        sel_addr = req_addr[0 +: ADDR_W];
        sel_data = req_data[0 +: DATA_W];
        case (xfer_id)
            2'd1: begin
                sel_addr = req_addr[ADDR_W +: ADDR_W];
                sel_data = req_data[DATA_W +: DATA_W];
            end
            2'd2: begin
                sel_addr = req_addr[2*ADDR_W +: ADDR_W];
                sel_data = req_data[2*DATA_W +: DATA_W];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB:   if (clear_start) state_d = ST_CLEAR;
            ST_CLEAR: if (clear_last)  state_d = ST_ARB;
            default:  state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_ARB;
        else          state_q <= state_d;
    end

    // The write port is registered; idle cycles drop fb_we but hold address and data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fb_we         <= 1'b0;
            fb_addr       <= '0;
            fb_wdata      <= '0;
            grant_id      <= 2'd0;
            clear_busy    <= 1'b0;
            clear_done    <= 1'b0;
            rr_ptr        <= 2'd0;
            lock_owner    <= 2'd0;
            locked        <= 1'b0;
            lock_cnt      <= '0;
            clear_idx     <= '0;
            clear_color_q <= '0;
        end else begin
            fb_we      <= 1'b0;
            clear_done <= 1'b0;
            clear_busy <= start_clear || (state_q == ST_CLEAR);
            if (state_q == ST_CLEAR) begin
                fb_we     <= 1'b1;
                fb_addr   <= clear_idx[ADDR_W-1:0];
                fb_wdata  <= clear_color_q;
                clear_idx <= clear_idx + 1'b1;
                if (clear_last) begin
                    clear_done <= 1'b1;
                    rr_ptr     <= 2'd0;
                end
            end else if (start_clear) begin
                clear_color_q <= clear_color;
                clear_idx     <= '0;
                locked        <= 1'b0;
                lock_cnt      <= '0;
            end else if (xfer) begin
                fb_we      <= 1'b1;
                fb_addr    <= sel_addr;
                fb_wdata   <= sel_data;
                grant_id   <= xfer_id;
                rr_ptr     <= ptr_after(xfer_id);
                lock_owner <= xfer_id;
                locked     <= req_lock[xfer_id];
                lock_cnt   <= '0;
            end else if (locked) begin
                // A lock owner that stays idle too long loses the bus.
                if (lock_cnt == CNT_LAST) begin
                    locked   <= 1'b0;
                    lock_cnt <= '0;
                    rr_ptr   <= ptr_after(lock_owner);
                end else begin
                    lock_cnt <= lock_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed self-checking bench for fb_write_arbiter (FB_WORDS=8, LOCK_MAX=4).
module tb_fb_write_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_lock;
    logic [47:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        clear_start;
    logic [31:0] clear_color;
    logic        clear_busy;
    logic        clear_done;
    logic [1:0]  grant_id;
    logic        fb_we;
    logic [15:0] fb_addr;
    logic [31:0] fb_wdata;

    int num_asserts = 0;
    int num_fail    = 0;

    logic [15:0] a_tab [3] = '{16'h1000, 16'h2000, 16'h3000};
    logic [31:0] d_tab [3] = '{32'hAAAA0000, 32'hBBBB0001, 32'hCCCC0002};
    logic [2:0]  rr_ready_exp [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [1:0]  rr_grant_exp [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

    fb_write_arbiter #(
        .ADDR_W  (16),
        .DATA_W  (32),
        .FB_WORDS(8),
        .LOCK_MAX(4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_lock   (req_lock),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .clear_start(clear_start),
        .clear_color(clear_color),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .grant_id   (grant_id),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_wdata   (fb_wdata)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        num_asserts++;
        assert (observed === expected)
        else begin
            num_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_fb(input string tag, input logic we, input logic [15:0] addr,
                            input logic [31:0] data, input logic [1:0] gnt);
        check_output({tag, ".we"},    64'(fb_we),    64'(we));
        check_output({tag, ".addr"},  64'(fb_addr),  64'(addr));
        check_output({tag, ".data"},  64'(fb_wdata), 64'(data));
        check_output({tag, ".grant"}, 64'(grant_id), 64'(gnt));
    endtask

    task automatic apply_stimulus(input logic [2:0] valid, input logic [2:0] lock,
                                  input logic cs, input logic [31:0] color);
        req_valid   = valid;
        req_lock    = lock;
        clear_start = cs;
        clear_color = color;
    endtask

    initial begin
        reset_n  = 1'b0;
        req_addr = {a_tab[2], a_tab[1], a_tab[0]};
        req_data = {d_tab[2], d_tab[1], d_tab[0]};
        apply_stimulus(3'b000, 3'b000, 1'b0, 32'h0);

        // Reset state
        #2;
        check_fb("reset", 1'b0, 16'h0, 32'h0, 2'd0);
        check_output("reset.ready", 64'(req_ready), 64'(3'b000));
        check_output("reset.busy",  64'(clear_busy), 64'(1'b0));
        check_output("reset.done",  64'(clear_done), 64'(1'b0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_output("idle.we", 64'(fb_we), 64'(1'b0));

        // Round robin, all valid
        apply_stimulus(3'b111, 3'b000, 1'b0, 32'h0);
        for (int c = 0; c < 6; c++) begin
            #1 check_output($sformatf("rr%0d.ready", c), 64'(req_ready), 64'(rr_ready_exp[c]));
            @(negedge clk);
            check_fb($sformatf("rr%0d", c), 1'b1, a_tab[rr_grant_exp[c]], d_tab[rr_grant_exp[c]], rr_grant_exp[c]);
        end
        apply_stimulus(3'b000, 3'b000, 1'b0, 32'h0);
        #1 check_output("rr_end.ready", 64'(req_ready), 64'(3'b000));
        @(negedge clk);
        check_fb("rr_end", 1'b0, a_tab[2], d_tab[2], 2'd2);

        // Lock held by requester 1 for three transfers
        apply_stimulus(3'b010, 3'b010, 1'b0, 32'h0);
        #1 check_output("lk_a.ready", 64'(req_ready), 64'(3'b010));
        @(negedge clk);
        check_fb("lk_a", 1'b1, a_tab[1], d_tab[1], 2'd1);
        apply_stimulus(3'b111, 3'b010, 1'b0, 32'h0);
        #1 check_output("lk_b.ready", 64'(req_ready), 64'(3'b010));
        @(negedge clk);
        check_fb("lk_b", 1'b1, a_tab[1], d_tab[1], 2'd1);
        apply_stimulus(3'b111, 3'b000, 1'b0, 32'h0);
        #1 check_output("lk_c.ready", 64'(req_ready), 64'(3'b010));
        @(negedge clk);
        check_fb("lk_c", 1'b1, a_tab[1], d_tab[1], 2'd1);
        #1 check_output("lk_d.ready", 64'(req_ready), 64'(3'b100));
        @(negedge clk);
        check_fb("lk_d", 1'b1, a_tab[2], d_tab[2], 2'd2);
        #1 check_output("lk_e.ready", 64'(req_ready), 64'(3'b001));
        @(negedge clk);
        check_fb("lk_e", 1'b1, a_tab[0], d_tab[0], 2'd0);
        apply_stimulus(3'b000, 3'b000, 1'b0, 32'h0);
        @(negedge clk);

        // Lock timeout: requester 0 goes idle while requester 2 waits
        apply_stimulus(3'b001, 3'b001, 1'b0, 32'h0);
        #1 check_output("to_take.ready", 64'(req_ready), 64'(3'b001));
        @(negedge clk);
        check_fb("to_take", 1'b1, a_tab[0], d_tab[0], 2'd0);
        apply_stimulus(3'b100, 3'b000, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1 check_output($sformatf("to_idle%0d.ready", i), 64'(req_ready), 64'(3'b000));
            @(negedge clk);
            check_fb($sformatf("to_idle%0d", i), 1'b0, a_tab[0], d_tab[0], 2'd0);
        end
        #1 check_output("to_drop.ready", 64'(req_ready), 64'(3'b100));
        @(negedge clk);
        check_fb("to_drop", 1'b1, a_tab[2], d_tab[2], 2'd2);
        apply_stimulus(3'b000, 3'b000, 1'b0, 32'h0);
        @(negedge clk);

        // Full clear racing with requester 0
        apply_stimulus(3'b001, 3'b000, 1'b1, 32'hDEADBEEF);
        #1 check_output("clr_start.ready", 64'(req_ready), 64'(3'b000));
        @(negedge clk);
        apply_stimulus(3'b001, 3'b000, 1'b0, 32'h0);
        check_output("clr_c0.we",    64'(fb_we),      64'(1'b0));
        check_output("clr_c0.busy",  64'(clear_busy), 64'(1'b1));
        check_output("clr_c0.ready", 64'(req_ready),  64'(3'b000));
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check_output($sformatf("clr%0d.we", k),   64'(fb_we),      64'(1'b1));
            check_output($sformatf("clr%0d.addr", k), 64'(fb_addr),    64'(k - 1));
            check_output($sformatf("clr%0d.data", k), 64'(fb_wdata),   64'(32'hDEADBEEF));
            check_output($sformatf("clr%0d.busy", k), 64'(clear_busy), 64'(1'b1));
            check_output($sformatf("clr%0d.done", k), 64'(clear_done), 64'(k == 8));
            check_output($sformatf("clr%0d.ready", k), 64'(req_ready), 64'((k == 8) ? 3'b001 : 3'b000));
        end
        @(negedge clk);
        check_fb("clr_after", 1'b1, a_tab[0], d_tab[0], 2'd0);
        check_output("clr_after.busy", 64'(clear_busy), 64'(1'b0));
        check_output("clr_after.done", 64'(clear_done), 64'(1'b0));
        apply_stimulus(3'b000, 3'b000, 1'b0, 32'h0);
        @(negedge clk);

        // Reset asserted in the middle of a clear
        apply_stimulus(3'b000, 3'b000, 1'b1, 32'h12345678);
        #1 check_output("rc_start.ready", 64'(req_ready), 64'(3'b000));
        @(negedge clk);
        apply_stimulus(3'b000, 3'b000, 1'b0, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check_output($sformatf("rc%0d.addr", k), 64'(fb_addr), 64'(k - 1));
            check_output($sformatf("rc%0d.data", k), 64'(fb_wdata), 64'(32'h12345678));
        end
        #2 reset_n = 1'b0;
        #1;
        check_fb("rc_reset", 1'b0, 16'h0, 32'h0, 2'd0);
        check_output("rc_reset.busy", 64'(clear_busy), 64'(1'b0));
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_output($sformatf("rc_post%0d.we", i),   64'(fb_we),      64'(1'b0));
            check_output($sformatf("rc_post%0d.busy", i), 64'(clear_busy), 64'(1'b0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_asserts, num_fail);
        $finish;
    end

endmodule
